// File: rtl/eth_pkg.sv
// Shared constants and read-side state encoding for the UDP payload path.
package eth_pkg;

  localparam int unsigned MAX_UDP_PAYLOAD = 1472;
  localparam int unsigned LEN_WIDTH_DEF   = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } framer_state_e;

endpackage

// File: rtl/framer_len_fifo.sv
// Small synchronous FIFO of committed frame lengths; head is visible on dout (fall-through).
module framer_len_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/udp_payload_framer.sv
// Buffers an unframed byte stream and emits it as contiguous AXIS datagrams,
// cut by length or flushed after an idle timeout.
module udp_payload_framer
  import eth_pkg::*;
#(
  parameter int unsigned DEPTH          = 2048,
  parameter int unsigned LEN_WIDTH      = LEN_WIDTH_DEF,
  parameter int unsigned LEN_FIFO_DEPTH = 4,
  parameter int unsigned MAX_FRAME_LEN  = MAX_UDP_PAYLOAD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           s_byte_tdata,
  input  logic                 s_byte_tvalid,
  output logic                 s_byte_tready,
  input  logic [LEN_WIDTH-1:0] cfg_frame_len,
  input  logic [15:0]          cfg_timeout,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 busy,
  output logic [LEN_WIDTH:0]   buf_level,
  output logic [15:0]          frames_sent
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned PW        = AW + 1;
  localparam int unsigned LW        = LEN_WIDTH + 1;
  localparam int unsigned LEVEL_MAX = (1 << LW) - 1;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_FRAME_LEN);

  logic [7:0]           ring [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d, level_c;
  logic [LEN_WIDTH-1:0] pend_cnt, eff_len, tx_rem, len_dout;
  logic [15:0]          idle_cnt;
  framer_state_e        state, state_d;
  logic                 ring_full, accept, timeout_hit;
  logic                 commit_req, commit_stalled, commit_fire;
  logic                 len_full, len_empty, len_pop;
  logic                 load_rd, advance, rd_en;
  logic [AW-1:0]        rd_addr;

  assign m_axis_tuser = 1'b0;

  // Write side: accept bytes, decide when the pending run becomes a frame.
  assign ring_full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign eff_len        = (cfg_frame_len == '0 || cfg_frame_len > MAX_LEN) ? MAX_LEN : cfg_frame_len;
  assign timeout_hit    = (cfg_timeout != 16'd0) && (pend_cnt != '0) && (idle_cnt == cfg_timeout);
  assign commit_req     = (pend_cnt >= eff_len) || timeout_hit;
  assign commit_stalled = commit_req && len_full;
  assign commit_fire    = commit_req && !len_full;
  assign s_byte_tready  = !rst && !ring_full && !commit_stalled;
  assign accept         = s_byte_tvalid && s_byte_tready;

  assign wr_ptr_d = wr_ptr + PW'(accept);
  assign rd_ptr_d = rd_ptr + PW'(advance);
  assign level_c  = wr_ptr_d - rd_ptr_d;

  always_ff @(posedge clk) begin
    if (accept) ring[wr_ptr[AW-1:0]] <= s_byte_tdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      pend_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr_d;
      if (commit_fire) begin
        pend_cnt <= LEN_WIDTH'(accept);
        idle_cnt <= '0;
      end else if (accept) begin
        pend_cnt <= pend_cnt + LEN_WIDTH'(1);
        idle_cnt <= '0;
      end else if (pend_cnt != '0 && !commit_stalled) begin
        idle_cnt <= idle_cnt + 16'd1;
      end
    end
  end

  framer_len_fifo #(
    .DEPTH (LEN_FIFO_DEPTH),
    .WIDTH (LEN_WIDTH)
  ) u_len_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (commit_fire),
    .din   (pend_cnt),
    .pop   (len_pop),
    .dout  (len_dout),
    .full  (len_full),
    .empty (len_empty)
  );

  // Read FSM: next-state and per-cycle read controls.
  always_comb begin
    state_d = state;
    len_pop = 1'b0;
    load_rd = 1'b0;
    advance = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!len_empty) begin
          len_pop = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_rd = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (m_axis_tvalid && m_axis_tready) begin
          advance = 1'b1;
          if (tx_rem == LEN_WIDTH'(1)) begin
            if (!len_empty) begin
              len_pop = 1'b1;
              state_d = ST_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Prefetch the following byte on each mid-frame handshake so a frame has no bubbles.
  assign rd_en   = load_rd || (advance && tx_rem != LEN_WIDTH'(1));
  assign rd_addr = load_rd ? rd_ptr[AW-1:0] : rd_ptr_d[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      rd_ptr        <= '0;
      tx_rem        <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frames_sent   <= '0;
      busy          <= 1'b0;
      buf_level     <= '0;
    end else begin
      state  <= state_d;
      rd_ptr <= rd_ptr_d;
      if (len_pop)      tx_rem <= len_dout;
      else if (advance) tx_rem <= tx_rem - LEN_WIDTH'(1);
      if (rd_en) m_axis_tdata <= ring[rd_addr];
      if (load_rd) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= (tx_rem == LEN_WIDTH'(1));
      end else if (advance) begin
        if (tx_rem == LEN_WIDTH'(1)) begin
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
          frames_sent   <= frames_sent + 16'd1;
        end else begin
          m_axis_tlast  <= (tx_rem == LEN_WIDTH'(2));
        end
      end
      // Going idle implies the queue was empty, so only a fresh commit keeps it busy.
      busy      <= (state_d != ST_IDLE) || commit_fire;
      buf_level <= (32'(level_c) > LEVEL_MAX) ? LW'(LEVEL_MAX) : LW'(level_c);
    end
  end

endmodule

// File: tb/tb_udp_payload_framer.sv
// Directed, table-driven bench for udp_payload_framer with an output scoreboard.
module tb_udp_payload_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [10:0] cfg_len = 11'd4;
  logic [15:0] cfg_tmo = 16'd0;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic        m_tuser;
  logic        busy;
  logic [11:0] buf_level;
  logic [15:0] frames_sent;

  int          n_vec = 0;
  int          n_err = 0;
  int          out_cnt = 0;
  int          pos = 0;
  logic [7:0]  next_b = 8'h01;
  logic        rand_rdy = 1'b0;
  logic        rdy_level = 1'b0;
  logic [7:0]  byte_q[$];
  int          len_q[$];
  logic        hold_chk = 1'b0;
  logic [7:0]  hold_data = '0;
  logic        hold_last = 1'b0;

  typedef struct {
    int len_cfg;
    int tmo;
    int nbytes;
    int full_len;
    int n_full;
    int tail;
  } vec_t;

  vec_t vecs[7];

  udp_payload_framer dut (
    .clk           (clk),
    .rst           (rst),
    .s_byte_tdata  (s_tdata),
    .s_byte_tvalid (s_tvalid),
    .s_byte_tready (s_tready),
    .cfg_frame_len (cfg_len),
    .cfg_timeout   (cfg_tmo),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .busy          (busy),
    .buf_level     (buf_level),
    .frames_sent   (frames_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_level;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output scoreboard: data order, tlast placement, stability under stall, no mid-frame gaps.
  always @(negedge clk) begin
    if (rst) begin
      pos      = 0;
      hold_chk = 1'b0;
    end else begin
      if (hold_chk)
        check("hold_stable", 32'({m_tvalid, m_tlast, m_tdata}), 32'({1'b1, hold_last, hold_data}));
      if (pos != 0) check("no_gap", 32'(m_tvalid), 32'd1);
      if (m_tvalid && m_tready) begin
        out_cnt++;
        if (byte_q.size() == 0 || len_q.size() == 0) begin
          check("unexpected_byte", 32'(m_tdata), 32'hFFFF_FFFF);
        end else begin
          logic [7:0] eb;
          logic       el;
          eb = byte_q.pop_front();
          el = (pos + 1 == len_q[0]);
          check("out_data", 32'(m_tdata), 32'(eb));
          check("out_last", 32'(m_tlast), 32'(el));
          if (el) begin
            void'(len_q.pop_front());
            pos = 0;
          end else begin
            pos++;
          end
        end
      end
      hold_chk  = m_tvalid && !m_tready;
      hold_data = m_tdata;
      hold_last = m_tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer sequential bytes until nbytes accepted or max_low consecutive refusals.
  task automatic offer(input int nbytes, input int max_low, output int acc);
    int low;
    low = 0;
    acc = 0;
    while (acc < nbytes && low < max_low) begin
      s_tdata  = next_b;
      s_tvalid = 1'b1;
      @(negedge clk);
      if (s_tready) begin
        byte_q.push_back(next_b);
        next_b = next_b + 8'd1;
        acc++;
        low = 0;
      end else begin
        low++;
      end
      tick();
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((byte_q.size() != 0 || len_q.size() != 0) && n < 20000) begin
      tick();
      n++;
    end
    check("drain_left", 32'(byte_q.size() + len_q.size()), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    int acc;
    int base;
    int n;
    logic [7:0] first_b;

    //            len_cfg tmo nbytes full_len n_full tail
    vecs[0] = '{4,    0,  12,   4,    3, 0};
    vecs[1] = '{1,    0,  3,    1,    3, 0};
    vecs[2] = '{5,    3,  12,   5,    2, 2};
    vecs[3] = '{0,    10, 30,   1472, 0, 30};
    vecs[4] = '{2000, 0,  1472, 1472, 1, 0};
    vecs[5] = '{0,    0,  1472, 1472, 1, 0};
    vecs[6] = '{1472, 0,  1472, 1472, 1, 0};

    // Reset values
    tick();
    tick();
    check("rst_ready", 32'(s_tready), 32'd0);
    check("rst_outs", 32'({m_tvalid, m_tlast, m_tuser, busy}), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_level", 32'(buf_level), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", 32'(s_tready), 32'd1);

    // Table of single-burst cases under random output backpressure
    rand_rdy = 1'b1;
    for (int v = 0; v < 7; v++) begin
      cfg_len = 11'(vecs[v].len_cfg);
      cfg_tmo = 16'(vecs[v].tmo);
      tick();
      base = int'(frames_sent);
      for (int f = 0; f < vecs[v].n_full; f++) len_q.push_back(vecs[v].full_len);
      if (vecs[v].tail != 0) len_q.push_back(vecs[v].tail);
      offer(vecs[v].nbytes, 5000, acc);
      check($sformatf("v%0d_accepted", v), 32'(acc), 32'(vecs[v].nbytes));
      drain();
      check($sformatf("v%0d_frames", v), 32'(int'(frames_sent) - base),
            32'(vecs[v].n_full + ((vecs[v].tail != 0) ? 1 : 0)));
      check($sformatf("v%0d_level", v), 32'(buf_level), 32'd0);
      check($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
    end

    // Timeout flush lands exactly 20 idle cycles after the last byte
    rand_rdy  = 1'b0;
    rdy_level = 1'b1;
    cfg_len   = 11'd100;
    cfg_tmo   = 16'd20;
    tick();
    tick();
    base    = int'(frames_sent);
    first_b = next_b;
    len_q.push_back(7);
    offer(7, 5000, acc);
    repeat (20) tick();
    check("tmo_busy_before", 32'(busy), 32'd0);
    tick();
    check("tmo_busy_commit", 32'(busy), 32'd1);
    tick();
    check("tmo_valid_load", 32'(m_tvalid), 32'd0);
    tick();
    check("tmo_valid_first", 32'({m_tvalid, m_tdata}), 32'({1'b1, first_b}));
    drain();
    check("tmo_frames", 32'(int'(frames_sent) - base), 32'd1);

    // A byte arriving as the idle count is about to expire keeps the frame open
    cfg_tmo = 16'd5;
    tick();
    base = int'(frames_sent);
    len_q.push_back(4);
    offer(3, 5000, acc);
    repeat (4) tick();
    offer(1, 5000, acc);
    check("prio_no_commit", 32'(busy), 32'd0);
    drain();
    check("prio_frames", 32'(int'(frames_sent) - base), 32'd1);

    // Length-queue stall: one frame in flight, four queued, eight bytes pending
    rdy_level = 1'b0;
    cfg_len   = 11'd8;
    cfg_tmo   = 16'd0;
    tick();
    tick();
    base    = int'(frames_sent);
    first_b = next_b;
    for (int i = 0; i < 8; i++) len_q.push_back(8);
    offer(3000, 20, acc);
    check("qstall_accepted", 32'(acc), 32'd48);
    check("qstall_level", 32'(buf_level), 32'd48);
    check("qstall_ready", 32'(s_tready), 32'd0);
    check("qstall_busy", 32'(busy), 32'd1);
    check("qstall_head", 32'({m_tvalid, m_tdata}), 32'({1'b1, first_b}));
    rdy_level = 1'b1;
    offer(16, 5000, acc);
    check("qstall_more", 32'(acc), 32'd16);
    drain();
    check("qstall_frames", 32'(int'(frames_sent) - base), 32'd8);

    // Ring full, then lowering the frame length below the pending count
    rdy_level = 1'b0;
    cfg_len   = 11'd0;
    tick();
    tick();
    base = int'(frames_sent);
    len_q.push_back(1472);
    len_q.push_back(576);
    offer(3000, 20, acc);
    check("full_accepted", 32'(acc), 32'd2048);
    check("full_level", 32'(buf_level), 32'd2048);
    check("full_ready", 32'(s_tready), 32'd0);
    cfg_len  = 11'd100;
    rand_rdy = 1'b1;
    drain();
    check("full_frames", 32'(int'(frames_sent) - base), 32'd2);
    check("full_level_end", 32'(buf_level), 32'd0);

    // Reset after 3 of 10 bytes have been sent
    rand_rdy  = 1'b0;
    rdy_level = 1'b0;
    cfg_len   = 11'd10;
    tick();
    tick();
    len_q.push_back(10);
    offer(10, 5000, acc);
    n = 0;
    while (!m_tvalid && n < 50) begin
      tick();
      n++;
    end
    check("mid_valid_wait", 32'(m_tvalid), 32'd1);
    base      = out_cnt;
    rdy_level = 1'b1;
    n = 0;
    while (out_cnt - base < 3 && n < 50) begin
      tick();
      n++;
    end
    check("mid_sent3", 32'(out_cnt - base), 32'd3);
    rst = 1'b1;
    tick();
    byte_q.delete();
    len_q.delete();
    check("mid_rst_outs", 32'({m_tvalid, m_tlast, busy, s_tready}), 32'd0);
    check("mid_rst_tdata", 32'(m_tdata), 32'd0);
    check("mid_rst_level", 32'(buf_level), 32'd0);
    check("mid_rst_frames", 32'(frames_sent), 32'd0);
    rst = 1'b0;
    tick();
    len_q.push_back(10);
    offer(10, 5000, acc);
    check("post_rst_accepted", 32'(acc), 32'd10);
    drain();
    check("post_rst_frames", 32'(frames_sent), 32'd1);
    check("post_rst_level", 32'(buf_level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
